// File: rtl/seg7_pkg.sv
// ============================================================================
// seg7_pkg : shared widths and helpers for the 7-segment digit scanner
// Rev 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

    localparam int NIBBLE_W       = 4;
    localparam int DEF_NUM_DIGITS = 4;
    localparam int MAX_DIGITS     = 8;

    // Sliced to NUM_DIGITS by users; all anodes off for a common-anode display.
    localparam logic [MAX_DIGITS-1:0] ANODES_OFF = '1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_prescaler.sv
// ============================================================================
// seg7_prescaler : free-running slot counter 0..REFRESH_DIV-1 with terminal pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_prescaler #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_tc;

    assign w_tc = (r_cnt == CNT_W'(REFRESH_DIV - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tc) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = w_tc;

endmodule

`default_nettype wire

// File: rtl/seg7_digit_scanner.sv
// ============================================================================
// seg7_digit_scanner : multiplexed common-anode 7-seg scan driver with
//                      frame-aligned double buffering and leading-zero blanking
// Rev 1.0
// ============================================================================
`default_nettype none

module seg7_digit_scanner
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 1000,
    parameter int LZB_EN       = 1,
    parameter int IDX_W        = idx_width(NUM_DIGITS),
    parameter int VAL_W        = NIBBLE_W * NUM_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [VAL_W-1:0]      value,
    output logic [NIBBLE_W-1:0]   bcd,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  frame_tick
);

    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam logic [NUM_DIGITS-1:0] C_AN_OFF = ANODES_OFF[NUM_DIGITS-1:0];

    logic [CNT_W-1:0]      w_cnt;
    logic                  w_tc;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_wrap;
    logic                  w_blank_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [VAL_W-1:0]      w_display_nxt;
    logic [NUM_DIGITS-1:0] w_lit;
    logic                  w_any_nz;
    logic [NIBBLE_W-1:0]   w_bcd_nxt;
    logic [NUM_DIGITS-1:0] w_an_nxt;

    logic [IDX_W-1:0]      r_idx;
    logic [VAL_W-1:0]      r_display;
    logic [VAL_W-1:0]      r_pending;
    logic                  r_pending_vld;
    logic [NIBBLE_W-1:0]   r_bcd;
    logic [NUM_DIGITS-1:0] r_an_n;
    logic [IDX_W-1:0]      r_digit_idx;
    logic                  r_frame_tick;

    seg7_prescaler #(
        .REFRESH_DIV (REFRESH_DIV),
        .CNT_W       (CNT_W)
    ) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .o_cnt (w_cnt),
        .o_tc  (w_tc)
    );

    assign w_wrap    = w_tc && (r_idx == IDX_W'(NUM_DIGITS - 1));
    assign w_cnt_nxt = w_tc ? '0 : w_cnt + 1'b1;

    // Outputs are computed from post-edge state so the blank window lines up
    // with the new digit and no ghost of the next digit leaks before it.
    assign w_blank_nxt = (int'(w_cnt_nxt) < BLANK_CYCLES);

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_wrap) begin
            w_idx_nxt = '0;
        end else if (w_tc) begin
            w_idx_nxt = r_idx + 1'b1;
        end
    end

    // A load in the wrap cycle goes straight to the display.
    always_comb begin
        w_display_nxt = r_display;
        if (w_wrap) begin
            if (load) begin
                w_display_nxt = value;
            end else if (r_pending_vld) begin
                w_display_nxt = r_pending;
            end
        end
    end

    always_comb begin
        w_any_nz = 1'b0;
        w_lit    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_any_nz = w_any_nz | (|w_display_nxt[i*NIBBLE_W +: NIBBLE_W]);
            w_lit[i] = (LZB_EN == 0) || (i == 0) || w_any_nz;
        end
    end

    always_comb begin
        w_bcd_nxt = '0;
        w_an_nxt  = C_AN_OFF;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_idx_nxt == IDX_W'(i)) begin
                w_bcd_nxt = w_display_nxt[i*NIBBLE_W +: NIBBLE_W];
                if (!w_blank_nxt && w_lit[i]) begin
                    w_an_nxt[i] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx         <= '0;
            r_display     <= '0;
            r_pending     <= '0;
            r_pending_vld <= 1'b0;
            r_bcd         <= '0;
            r_an_n        <= C_AN_OFF;
            r_digit_idx   <= '0;
            r_frame_tick  <= 1'b0;
        end else begin
            r_idx         <= w_idx_nxt;
            r_display     <= w_display_nxt;
            if (load) begin
                r_pending <= value;
            end
            r_pending_vld <= w_wrap ? 1'b0 : (r_pending_vld | load);
            r_bcd         <= w_bcd_nxt;
            r_an_n        <= w_an_nxt;
            r_digit_idx   <= w_idx_nxt;
            r_frame_tick  <= w_wrap;
        end
    end

    assign bcd        = r_bcd;
    assign an_n       = r_an_n;
    assign digit_idx  = r_digit_idx;
    assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_seg7_digit_scanner.sv
// ============================================================================
// tb_seg7_digit_scanner : directed self-checking bench (4 digits, 8-cycle slots)
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_seg7_digit_scanner;

    logic        clk;
    logic        rst_n;
    logic        load;
    logic [15:0] value;
    logic [3:0]  bcd,  bcd2;
    logic [3:0]  an_n, an2;
    logic [1:0]  digit_idx, idx2;
    logic        frame_tick, ft2;

    int total = 0;
    int bad   = 0;

    seg7_digit_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .LZB_EN(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .bcd(bcd), .an_n(an_n), .digit_idx(digit_idx), .frame_tick(frame_tick)
    );

    seg7_digit_scanner #(
        .NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2), .LZB_EN(0)
    ) dut_nolzb (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value),
        .bcd(bcd2), .an_n(an2), .digit_idx(idx2), .frame_tick(ft2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_load(input logic [15:0] v);
        load  = 1'b1;
        value = v;
        tick();
        load  = 1'b0;
    endtask

    task automatic wait_frame();
        for (int k = 0; k < 100; k++) begin
            if (frame_tick === 1'b1) break;
            tick();
        end
        chk("frame_wait", frame_tick, 1);
    endtask

    // Samples one 8-cycle slot starting at its first cycle.
    task automatic check_slot(input int d, input logic [3:0] exp_bcd, input logic lit,
                              input logic ft_first);
        logic [3:0] one;
        logic [3:0] exp_an;
        logic [3:0] exp_an2;
        one = 4'b0001;
        for (int c = 0; c < 8; c++) begin
            exp_an2 = (c < 2) ? 4'hF : ~(one << d);
            exp_an  = lit ? exp_an2 : 4'hF;
            chk("an_n",      an_n,      exp_an);
            chk("bcd",       bcd,       exp_bcd);
            chk("digit_idx", digit_idx, d);
            chk("frame_tick", frame_tick, (c == 0) ? ft_first : 1'b0);
            chk("an_n_nolzb", an2,      exp_an2);
            chk("bcd_nolzb",  bcd2,     exp_bcd);
            tick();
        end
    endtask

    task automatic check_frame(input logic [15:0] v, input logic [3:0] lit, input logic ft);
        for (int d = 0; d < 4; d++) begin
            check_slot(d, v[d*4 +: 4], lit[d], ft && (d == 0));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        value = 16'h0000;

        repeat (3) begin
            tick();
            chk("rst_an_n",  an_n,       4'hF);
            chk("rst_bcd",   bcd,        4'h0);
            chk("rst_idx",   digit_idx,  2'd0);
            chk("rst_ft",    frame_tick, 1'b0);
        end
        rst_n = 1'b1;
        tick();
        chk("post_rst_an_n", an_n,       4'hF);
        chk("post_rst_bcd",  bcd,        4'h0);
        chk("post_rst_idx",  digit_idx,  2'd0);
        chk("post_rst_ft",   frame_tick, 1'b0);

        // Plain value, every digit lit.
        do_load(16'h1234);
        wait_frame();
        check_frame(16'h1234, 4'b1111, 1'b1);

        // Leading zeros on digits 3 and 2.
        do_load(16'h0050);
        wait_frame();
        check_frame(16'h0050, 4'b0011, 1'b1);

        // All zero: only digit 0 lit (all lit on the non-blanking instance).
        do_load(16'h0000);
        wait_frame();
        check_frame(16'h0000, 4'b0001, 1'b1);

        // Two loads mid-frame: current frame untouched, last load wins.
        repeat (12) tick();
        do_load(16'hAAAA);
        repeat (5) tick();
        do_load(16'hBBBB);
        for (int n = 0; n < 40; n++) begin
            if (frame_tick === 1'b1) break;
            chk("hold_bcd", bcd, 4'h0);
            tick();
        end
        chk("hold_boundary", frame_tick, 1'b1);
        check_frame(16'hBBBB, 4'b1111, 1'b1);

        // Load exactly on the wrap cycle commits without waiting a frame.
        repeat (31) tick();
        chk("pre_wrap_ft", frame_tick, 1'b0);
        load  = 1'b1;
        value = 16'h5678;
        tick();
        load  = 1'b0;
        chk("wrap_tick", frame_tick, 1'b1);
        check_frame(16'h5678, 4'b1111, 1'b1);

        // Reset in the middle of digit 2's active phase.
        repeat (19) tick();
        chk("mid_an_n", an_n,      4'b1011);
        chk("mid_idx",  digit_idx, 2'd2);
        chk("mid_bcd",  bcd,       4'h6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_frame(16'h0000, 4'b0001, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
